// File: rtl/acc_cpu_pkg.sv
// -----------------------------------------------------------------------------
// acc_cpu_pkg
// Shared types and constants for the accumulator processor:
//   op_e    - two-bit opcode field of an instruction word
//   state_e - fetch/decode/indirect/execute sequencer states
//   CLA..HLT - bit positions inside the register-group mask (instruction addr)
// -----------------------------------------------------------------------------
package acc_cpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_DBL = 2'b01,
    OP_LDA = 2'b10,
    OP_REG = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    INDIR,
    EXEC,
    HALT
  } state_e;

  // Register-group mask bits, applied in this order within one EXEC cycle.
  localparam int CLA = 0;
  localparam int CLE = 1;
  localparam int CMA = 2;
  localparam int CME = 3;
  localparam int HLT = 4;

endpackage

// File: rtl/acc_cpu_core_if.sv
// -----------------------------------------------------------------------------
// acc_cpu_core_if
// Control, program-load, debug and status signals of acc_cpu_core.
//   master : drives start/start_pc, ld_en/ld_addr/ld_data, dbg_addr;
//            observes dbg_data, busy, halted, ac, e, pc
//   slave  : the core side of the same signals
// -----------------------------------------------------------------------------
interface acc_cpu_core_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          start;
  logic [AW-1:0] start_pc;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          busy;
  logic          halted;
  logic [DW-1:0] ac;
  logic          e;
  logic [AW-1:0] pc;

  modport master (
    output start, start_pc, ld_en, ld_addr, ld_data, dbg_addr,
    input  dbg_data, busy, halted, ac, e, pc
  );

  modport slave (
    input  start, start_pc, ld_en, ld_addr, ld_data, dbg_addr,
    output dbg_data, busy, halted, ac, e, pc
  );
endinterface

// File: rtl/acc_cpu_core_csel_adder.sv
// -----------------------------------------------------------------------------
// csel_adder
// W-bit carry-select adder. The low half ripples from cin; the high half is
// computed for both possible carries in parallel and the low-half carry-out
// selects between them.
//   a, b : W-bit operands     cin  : carry in
//   s    : W-bit sum          cout : carry out
// -----------------------------------------------------------------------------
module csel_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  localparam int LW = W / 2;
  localparam int HW = W - LW;

  logic [LW:0] lo;
  logic [HW:0] hi0;
  logic [HW:0] hi1;

  assign lo  = {1'b0, a[LW-1:0]} + {1'b0, b[LW-1:0]} + {{LW{1'b0}}, cin};
  assign hi0 = {1'b0, a[W-1:LW]} + {1'b0, b[W-1:LW]};
  assign hi1 = hi0 + {{HW{1'b0}}, 1'b1};

  assign {cout, s} = lo[LW] ? {hi1, lo[LW-1:0]} : {hi0, lo[LW-1:0]};
endmodule

// File: rtl/acc_cpu_core.sv
// -----------------------------------------------------------------------------
// acc_cpu_core
// Clocked accumulator processor with an internal 2**AW x DW word memory.
// Sequencer: IDLE -> FETCH -> DECODE -> (INDIR) -> EXEC -> FETCH, or HALT.
// Instruction: I = bit DW-1, op = bits DW-2:DW-3, addr = bits AW-1:0.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start/start_pc      : begin execution (IDLE or HALT only)
//   bus.ld_en/ld_addr/ld_data : program load (while not busy)
//   bus.dbg_addr/dbg_data   : combinational memory read port
//   bus.busy/halted/ac/e/pc : status and architectural registers
// -----------------------------------------------------------------------------
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  acc_cpu_core_if.slave   bus
);

  logic [DW-1:0] mem [2**AW];

  state_e        state_q, state_d;
  logic [DW-1:0] ac_q, ac_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ar_q, ar_d;
  logic          e_q, e_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          ir_i;
  op_e           ir_op;
  logic [AW-1:0] ir_addr;
  logic [DW-1:0] operand;
  logic [DW-1:0] sum;
  logic          carry;

  assign ir_i    = ir_q[DW-1];
  assign ir_op   = op_e'(ir_q[DW-2:DW-3]);
  assign ir_addr = ir_q[AW-1:0];
  assign operand = mem[ar_q];

  csel_adder #(.W(DW)) u_add (
    .a    (ac_q),
    .b    (operand),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    ar_d      = ar_q;
    e_d       = e_q;
    busy_d    = busy_q;
    halted_d  = halted_q;
    mem_we    = 1'b0;
    mem_waddr = ar_q;
    mem_wdata = {operand[DW-2:0], 1'b0};

    unique case (state_q)
      IDLE, HALT: begin
        // Load and start may share an edge; the load lands first in memory
        // so the first FETCH sees it.
        if (bus.ld_en) begin
          mem_we    = 1'b1;
          mem_waddr = bus.ld_addr;
          mem_wdata = bus.ld_data;
        end
        if (bus.start) begin
          pc_d     = bus.start_pc;
          state_d  = FETCH;
          busy_d   = 1'b1;
          halted_d = 1'b0;
        end
      end

      FETCH: begin
        ir_d    = mem[pc_q];
        pc_d    = pc_q + AW'(1);
        state_d = DECODE;
      end

      DECODE: begin
        ar_d    = ir_addr;
        state_d = (ir_i && ir_op != OP_REG) ? INDIR : EXEC;
      end

      INDIR: begin
        ar_d    = operand[AW-1:0];
        state_d = EXEC;
      end

      EXEC: begin
        state_d = FETCH;
        unique case (ir_op)
          OP_ADD: begin
            ac_d = sum;
            e_d  = carry;
          end
          OP_DBL: begin
            mem_we = 1'b1;
            e_d    = operand[DW-1];
          end
          OP_LDA: ac_d = operand;
          OP_REG: begin
            if (ir_i) begin
              pc_d = ir_addr;
            end else begin
              // Mask bits act in sequence, so CLA+CMA yields all ones.
              if (ir_addr[CLA]) ac_d = '0;
              if (ir_addr[CLE]) e_d  = 1'b0;
              if (ir_addr[CMA]) ac_d = ~ac_d;
              if (ir_addr[CME]) e_d  = ~e_d;
              if (ir_addr[HLT]) begin
                state_d  = HALT;
                busy_d   = 1'b0;
                halted_d = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ac_q     <= '0;
      ir_q     <= '0;
      pc_q     <= '0;
      ar_q     <= '0;
      e_q      <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ac_q     <= ac_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      ar_q     <= ar_d;
      e_q      <= e_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: the memory array has no reset so it maps onto plain RAM and keeps
  // the program across resets. A DBL write cannot land on a reset edge: the
  // asynchronous reset has already forced the sequencer out of EXEC.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.dbg_data = mem[bus.dbg_addr];
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;
  assign bus.ac       = ac_q;
  assign bus.e        = e_q;
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_acc_cpu_core
// Directed bench for acc_cpu_core (DW=8, AW=5). An instruction-level model
// predicts architectural state, instruction lengths and memory contents;
// the DUT is compared against it every cycle of a run, and literal values
// pin the model for each scenario.
// -----------------------------------------------------------------------------
module tb_acc_cpu_core;
  localparam int DW = 8;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_cpu_core_if #(.DW(DW), .AW(AW)) bus ();

  acc_cpu_core #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Instruction-level reference model.
  logic [7:0] mmem [32];
  logic [7:0] m_ac;
  logic       m_e;
  logic [4:0] m_pc;

  // Expected state after the last edge of each instruction.
  int         n_cp;
  int         cp_cyc [128];
  logic [7:0] cp_ac  [128];
  logic       cp_e   [128];
  logic [4:0] cp_pc  [128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Executes from pc0 until HLT; returns total clock edges after the start edge.
  task automatic model_run(input logic [4:0] pc0, output int total, output bit ok);
    logic [4:0] pc;
    logic [7:0] ir;
    logic [4:0] a;
    logic [4:0] ea;
    logic [8:0] wide;
    int cyc;
    int len;
    bit halt;
    pc = pc0; cyc = 0; halt = 0; n_cp = 0;
    for (int step = 0; step < 100 && !halt; step++) begin
      ir = mmem[pc];
      pc = pc + 5'd1;
      a  = ir[4:0];
      if (ir[6:5] != 2'b11) begin
        ea  = ir[7] ? mmem[a][4:0] : a;
        len = ir[7] ? 4 : 3;
        case (ir[6:5])
          2'b00: begin
            wide = {1'b0, m_ac} + {1'b0, mmem[ea]};
            m_ac = wide[7:0];
            m_e  = wide[8];
          end
          2'b01: begin
            m_e       = mmem[ea][7];
            mmem[ea]  = {mmem[ea][6:0], 1'b0};
          end
          default: m_ac = mmem[ea];
        endcase
      end else begin
        len = 3;
        if (ir[7]) pc = a;
        else begin
          if (a[0]) m_ac = 8'h00;
          if (a[1]) m_e  = 1'b0;
          if (a[2]) m_ac = ~m_ac;
          if (a[3]) m_e  = ~m_e;
          if (a[4]) halt = 1;
        end
      end
      cyc += len;
      cp_cyc[n_cp] = cyc; cp_ac[n_cp] = m_ac; cp_e[n_cp] = m_e; cp_pc[n_cp] = pc;
      n_cp++;
    end
    m_pc  = pc;
    total = cyc;
    ok    = halt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ac = 8'h00; m_e = 1'b0; m_pc = 5'd0;
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
    mmem[a] = d;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      #1;
      check($sformatf("%s mem[%0d]", tag, i), 32'(bus.dbg_data), 32'(mmem[i]));
    end
  endtask

  task automatic check_regs(input string tag, input logic busy_x, input logic halted_x);
    check({tag, " ac"},     32'(bus.ac),     32'(m_ac));
    check({tag, " e"},      32'(bus.e),      32'(m_e));
    check({tag, " pc"},     32'(bus.pc),     32'(m_pc));
    check({tag, " busy"},   32'(bus.busy),   32'(busy_x));
    check({tag, " halted"}, 32'(bus.halted), 32'(halted_x));
  endtask

  // Starts at pc0 and compares the DUT every cycle until the modelled halt.
  // poke_k > 0 drives an ld_en + start pulse during that busy cycle.
  task automatic run_check(input string tag, input logic [4:0] pc0, input int poke_k,
                           input logic [4:0] poke_addr, input logic [7:0] poke_data,
                           input logic [4:0] poke_pc, output int total);
    bit ok;
    int cp;
    model_run(pc0, total, ok);
    check({tag, " model halts"}, 32'(ok), 32'd1);
    @(negedge clk);
    bus.start = 1'b1; bus.start_pc = pc0;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " busy after start"},   32'(bus.busy),   32'd1);
    check({tag, " halted after start"}, 32'(bus.halted), 32'd0);
    cp = 0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      bus.ld_en = 1'b0; bus.start = 1'b0;
      check($sformatf("%s busy@%0d", tag, k),   32'(bus.busy),   32'(k < total));
      check($sformatf("%s halted@%0d", tag, k), 32'(bus.halted), 32'(k >= total));
      if (cp < n_cp && cp_cyc[cp] == k) begin
        check($sformatf("%s ac@%0d", tag, k), 32'(bus.ac), 32'(cp_ac[cp]));
        check($sformatf("%s e@%0d", tag, k),  32'(bus.e),  32'(cp_e[cp]));
        check($sformatf("%s pc@%0d", tag, k), 32'(bus.pc), 32'(cp_pc[cp]));
        cp++;
      end
      if (k == poke_k) begin
        bus.ld_en = 1'b1; bus.ld_addr = poke_addr; bus.ld_data = poke_data;
        bus.start = 1'b1; bus.start_pc = poke_pc;
      end
    end
    bus.ld_en = 1'b0; bus.start = 1'b0;
    check_mem(tag);
  endtask

  int total;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.start_pc = '0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.dbg_addr = '0;
    do_reset();
    check_regs("reset", 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) load(5'(i), 8'h00);

    // LDA/ADD with carry.
    load(5'd0, 8'h4A); load(5'd1, 8'h0B); load(5'd2, 8'h70);
    load(5'd10, 8'hF0); load(5'd11, 8'h20);
    run_check("t1", 5'd0, 0, '0, '0, '0, total);
    check("t1 edges", 32'(total), 32'd9);
    check("t1 ac lit", 32'(bus.ac), 32'h10);
    check("t1 e lit",  32'(bus.e),  32'd1);
    check("t1 pc lit", 32'(bus.pc), 32'd3);

    // Indirect LDA.
    load(5'd0, 8'hCA); load(5'd10, 8'h0C); load(5'd12, 8'h55); load(5'd1, 8'h70);
    run_check("t2", 5'd0, 0, '0, '0, '0, total);
    check("t2 edges", 32'(total), 32'd7);
    check("t2 ac lit", 32'(bus.ac), 32'h55);

    // DBL write-back.
    do_reset();
    load(5'd0, 8'h2A); load(5'd10, 8'h81); load(5'd1, 8'h70);
    run_check("t3", 5'd0, 0, '0, '0, '0, total);
    bus.dbg_addr = 5'd10; #1;
    check("t3 dbg lit", 32'(bus.dbg_data), 32'h02);
    check("t3 e lit",   32'(bus.e),  32'd1);
    check("t3 ac lit",  32'(bus.ac), 32'h00);

    // Register group, BUN and PC wrap.
    do_reset();
    check_regs("reset2", 1'b0, 1'b0);
    load(5'd31, 8'h65); load(5'd0, 8'hE4); load(5'd4, 8'h78);
    run_check("t4", 5'd31, 0, '0, '0, '0, total);
    check("t4 ac lit", 32'(bus.ac), 32'hFF);
    check("t4 e lit",  32'(bus.e),  32'd1);
    check("t4 pc lit", 32'(bus.pc), 32'd5);

    // Busy lockout, then restart from HALT at a new address.
    load(5'd0, 8'h4A); load(5'd1, 8'h0B); load(5'd2, 8'h70);
    load(5'd10, 8'hF0); load(5'd11, 8'h20); load(5'd20, 8'h71);
    run_check("t5", 5'd0, 2, 5'd2, 8'h00, 5'd20, total);
    check("t5 ac lit",     32'(bus.ac),     32'h10);
    check("t5 pc lit",     32'(bus.pc),     32'd3);
    check("t5 halted lit", 32'(bus.halted), 32'd1);
    run_check("t5r", 5'd20, 0, '0, '0, '0, total);
    check("t5r ac lit", 32'(bus.ac), 32'h00);
    check("t5r pc lit", 32'(bus.pc), 32'd21);

    // Reset lands on the DBL EXEC edge.
    load(5'd0, 8'h2A); load(5'd10, 8'h81); load(5'd1, 8'h70);
    @(negedge clk);
    bus.start = 1'b1; bus.start_pc = 5'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_ac = 8'h00; m_e = 1'b0; m_pc = 5'd0;
    check_regs("t6", 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.dbg_addr = 5'd10; #1;
    check("t6 mem10 lit", 32'(bus.dbg_data), 32'h81);
    check_mem("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
